// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared types and constants for the single-port-RAM FIFO controller.
package fifo_pkg;

  // Default geometry of the attached RAM: 32 words of 8 bits.
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  // Encodings of the RAM RW_sel pin.
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Controller state: which operation (if any) owns the RAM port this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// Client-side handshake bundle of the FIFO controller: write/read requests,
// their acknowledges and the occupancy status.
interface fifo_ram_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;

  // Client side: raises requests, sees acknowledges and status.
  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_data, rd_valid, full, empty, count
  );

  // Controller side.
  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_data, rd_valid, full, empty, count
  );

endinterface

// File: rtl/fifo_ram_ctrl_rr_arbiter.sv
// Two-requester round-robin arbiter (write vs read) with a registered
// "last tie went to read" flag. Grants are combinational from the
// eligibility inputs; the flag only moves when both sides compete.
module fifo_rr_arbiter
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wr_ok,
  input  logic rd_ok,
  output logic grant_wr,
  output logic grant_rd
);

  // 1 = the last contested grant went to the read side, so the next tie
  // goes to the write side. Reset/flush value makes the first tie a write.
  logic last_rd_reg;
  logic last_rd_next;

  // Grant decode and priority-flag update; a flush suppresses all grants.
  always_comb begin
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    last_rd_next = last_rd_reg;
    if (clr) begin
      last_rd_next = 1'b1;
    end else if (wr_ok && rd_ok) begin
      if (last_rd_reg) begin
        grant_wr     = 1'b1;
        last_rd_next = 1'b0;
      end else begin
        grant_rd     = 1'b1;
        last_rd_next = 1'b1;
      end
    end else if (wr_ok) begin
      grant_wr = 1'b1;
    end else if (rd_ok) begin
      grant_rd = 1'b1;
    end
  end

  // Priority flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_reg <= 1'b1;
    end else begin
      last_rd_reg <= last_rd_next;
    end
  end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Sequencing controller that turns a single-port tri-state RAM into a
// synchronous FIFO. One RAM access per cycle: the grant edge books the
// pointers and count, the following cycle performs the access on the port.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  fifo_ram_ctrl_if.slave    cli,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw_sel,
  output logic              ram_chip_sel,
  inout  wire  [DATA_W-1:0] ram_io
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ZERO = '0;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W-1:0]   rd_ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_valid_reg;

  logic                full;
  logic                empty;
  logic                wr_ok;
  logic                rd_ok;
  logic                grant_wr;
  logic                grant_rd;
  logic                bus_oe;
  logic                read_done;

  // Status flags come straight from the registered count, so an operation
  // already booked at the grant edge is accounted for before the next one.
  assign full  = (count_reg == COUNT_FULL);
  assign empty = (count_reg == COUNT_ZERO);
  assign wr_ok = cli.wr_req & ~full;
  assign rd_ok = cli.rd_req & ~empty;

  fifo_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_ok    (wr_ok),
    .rd_ok    (rd_ok),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  // Next state follows the grant in every state: back-to-back ops need no IDLE.
  always_comb begin
    state_next = IDLE;
    if (!clr) begin
      if (grant_wr) begin
        state_next = WRITE;
      end else if (grant_rd) begin
        state_next = READ;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pointers, occupancy and the address/data latched for the access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (grant_wr) begin
      addr_reg   <= wr_ptr_reg;
      wdata_reg  <= cli.wr_data;
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      count_reg  <= count_reg + 1'b1;
    end else if (grant_rd) begin
      addr_reg   <= rd_ptr_reg;
      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_reg - 1'b1;
    end
  end

  // A READ cycle still runs on the port during a flush, but its result is
  // discarded so the client never sees data from a flushed FIFO.
  assign read_done = (state_reg == READ) && !clr;

  // Capture read data at the end of the READ cycle and flag it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= read_done;
      if (read_done) begin
        rd_data_reg <= ram_io;
      end
    end
  end

  // RAM port decoded from registered state only, so it is glitch-free and
  // the bus is released as soon as the state leaves WRITE.
  assign bus_oe       = (state_reg == WRITE);
  assign ram_chip_sel = (state_reg != IDLE);
  assign ram_rw_sel   = bus_oe ? RW_WRITE : RW_READ;
  assign ram_addr     = addr_reg;
  assign ram_io       = bus_oe ? wdata_reg : {DATA_W{1'bz}};

  // Client-side outputs.
  assign cli.wr_ack   = (state_reg == WRITE);
  assign cli.rd_data  = rd_data_reg;
  assign cli.rd_valid = rd_valid_reg;
  assign cli.full     = full;
  assign cli.empty    = empty;
  assign cli.count    = count_reg;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl: a behavioural 32x8 RAM on the
// tri-state bus, a read-data scoreboard, a per-cycle vector table for the
// arbitration sequence, and hand-written flush/reset corner cases.
module tb_fifo_ram_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fifo_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) cli ();
  wire  [DW-1:0] ram_io;
  logic [AW-1:0] ram_addr;
  logic          ram_rw_sel;
  logic          ram_chip_sel;

  fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .cli          (cli),
    .ram_addr     (ram_addr),
    .ram_rw_sel   (ram_rw_sel),
    .ram_chip_sel (ram_chip_sel),
    .ram_io       (ram_io)
  );

  // Behavioural RAM: drives the bus during reads, latches writes on the edge.
  logic [DW-1:0] mem [DEPTH];
  assign ram_io = (ram_chip_sel && (ram_rw_sel == RW_READ)) ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (ram_chip_sel && (ram_rw_sel == RW_WRITE)) mem[ram_addr] <= ram_io;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int wr_acks = 0;
  int rd_valids = 0;
  int first_rv_cyc = -1;
  int last_rv_cyc = -1;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic          ack;
    logic          cs;
    logic          rw;
    logic [AW-1:0] addr;
    int            cnt;
    logic          rv;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cli.wr_req = 1'b0;
    cli.rd_req = 1'b0;
    clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    int k, w0, r0;
    cli.wr_req = 1'b0;
    cli.rd_req = 1'b0;
    cli.wr_data = '0;

    // Arbitration vectors applied after reset: {wr, rd, data, ack, cs, rw, addr, count, rd_valid}.
    tbl[0]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 5'd0, 1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 5'd1, 2, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 1'b1, 5'd2, 3, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 5'd3, 4, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 5'd4, 5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 5'd0, 4, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 5'd5, 5, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 5'd1, 4, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 5'd6, 5, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b0, 5'd2, 4, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'hB6, 1'b1, 1'b1, 1'b1, 5'd7, 5, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'hB7, 1'b0, 1'b1, 1'b0, 5'd3, 4, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 4, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 4, 1'b0};

    // Output monitor: counts pulses and pops the scoreboard on every rd_valid.
    fork
      forever begin
        logic [DW-1:0] exp_d;
        @(negedge clk);
        if (rst_n) begin
          if (cli.wr_ack) wr_acks++;
          if (cli.rd_valid) begin
            rd_valids++;
            last_rv_cyc = cyc;
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rd_unexpected: got rd_valid data=%02h expected no read (cycle %0d)", cli.rd_data, cyc);
            end else begin
              exp_d = sb.pop_front();
              $display("read  data=%02h expect=%02h cycle=%0d", cli.rd_data, exp_d, cyc);
              check("rd_data", int'(cli.rd_data), int'(exp_d));
            end
          end
        end
      end
    join_none

    // ---------------- reset state
    do_reset();
    #1;
    check("rst_empty", int'(cli.empty), 1);
    check("rst_full", int'(cli.full), 0);
    check("rst_count", int'(cli.count), 0);
    check("rst_cs", int'(ram_chip_sel), 0);
    check("rst_rw", int'(ram_rw_sel), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_wr_ack", int'(cli.wr_ack), 0);
    check("rst_rd_valid", int'(cli.rd_valid), 0);
    check("rst_rd_data", int'(cli.rd_data), 0);
    check("rst_bus_oe", int'(dut.bus_oe), 0);
    @(negedge clk);

    // ---------------- fill 32 words
    w0 = wr_acks;
    cli.wr_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cli.wr_data = DW'(i);
      sb.push_back(DW'(i));
      step();
    end
    cli.wr_req = 1'b0;
    check("fill_count", int'(cli.count), DEPTH);
    check("fill_full", int'(cli.full), 1);
    check("fill_empty", int'(cli.empty), 0);
    cli.wr_req = 1'b1;
    cli.wr_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ovf_cs", int'(ram_chip_sel), 0);
      check("ovf_wr_ack", int'(cli.wr_ack), 0);
    end
    cli.wr_req = 1'b0;
    check("fill_acks", wr_acks - w0, DEPTH);
    check("ovf_count", int'(cli.count), DEPTH);
    $display("fill  acks=%0d count=%0d", wr_acks - w0, cli.count);

    // ---------------- drain 32 words
    r0 = rd_valids;
    first_rv_cyc = -1;
    k = cyc;
    cli.rd_req = 1'b1;
    repeat (DEPTH) step();
    cli.rd_req = 1'b0;
    check("drain_empty", int'(cli.empty), 1);
    check("drain_count", int'(cli.count), 0);
    repeat (4) step();
    check("drain_valids", rd_valids - r0, DEPTH);
    check("drain_first_lat", first_rv_cyc, k + 2);
    check("drain_last_lat", last_rv_cyc, k + DEPTH + 1);
    r0 = rd_valids;
    cli.rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("underflow_cs", int'(ram_chip_sel), 0);
    end
    cli.rd_req = 1'b0;
    repeat (3) step();
    check("underflow_valids", rd_valids - r0, 0);

    // ---------------- table: fill to 4, then contention
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cli.wr_req  = tbl[i].wr;
      cli.rd_req  = tbl[i].rd;
      cli.wr_data = tbl[i].d;
      if (tbl[i].ack) sb.push_back(tbl[i].d);
      step();
      $display("vec %0d wr=%0d rd=%0d ack=%0d cs=%0d rw=%0d addr=%0d count=%0d rv=%0d",
               i, tbl[i].wr, tbl[i].rd, cli.wr_ack, ram_chip_sel, ram_rw_sel, ram_addr, cli.count, cli.rd_valid);
      check("vec_wr_ack", int'(cli.wr_ack), int'(tbl[i].ack));
      check("vec_cs", int'(ram_chip_sel), int'(tbl[i].cs));
      check("vec_rw", int'(ram_rw_sel), int'(tbl[i].rw));
      check("vec_addr", int'(ram_addr), int'(tbl[i].addr));
      check("vec_count", int'(cli.count), tbl[i].cnt);
      check("vec_rd_valid", int'(cli.rd_valid), int'(tbl[i].rv));
    end

    // ---------------- wrap: 40 write/read pairs starting at count 4
    r0 = rd_valids;
    for (int i = 0; i < 40; i++) begin
      cli.wr_req = 1'b1;
      cli.rd_req = 1'b0;
      cli.wr_data = DW'(8'h40 + i);
      sb.push_back(DW'(8'h40 + i));
      step();
      cli.wr_req = 1'b0;
      cli.rd_req = 1'b1;
      step();
    end
    cli.rd_req = 1'b0;
    repeat (4) step();
    check("wrap_valids", rd_valids - r0, 40);
    check("wrap_count", int'(cli.count), 4);

    // ---------------- flush at count 10, with a write request pending
    cli.wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cli.wr_data = DW'(8'h60 + i);
      step();
    end
    check("pre_clr_count", int'(cli.count), 10);
    clr = 1'b1;
    cli.wr_data = 8'hEE;
    step();
    clr = 1'b0;
    cli.wr_req = 1'b0;
    check("clr_count", int'(cli.count), 0);
    check("clr_empty", int'(cli.empty), 1);
    check("clr_wr_ack", int'(cli.wr_ack), 0);
    check("clr_cs", int'(ram_chip_sel), 0);
    sb.delete();

    // write then immediate read of the same slot (pointers restart at 0)
    cli.wr_req = 1'b1;
    cli.wr_data = 8'h77;
    sb.push_back(8'h77);
    step();
    check("post_clr_waddr", int'(ram_addr), 0);
    check("post_clr_rw", int'(ram_rw_sel), 1);
    cli.wr_req = 1'b0;
    cli.rd_req = 1'b1;
    step();
    cli.rd_req = 1'b0;
    check("post_clr_raddr", int'(ram_addr), 0);
    check("post_clr_read_cs", int'(ram_chip_sel), 1);
    check("post_clr_read_rw", int'(ram_rw_sel), 0);
    repeat (3) step();

    // clr during a READ cycle: port access completes, rd_valid suppressed
    cli.wr_req = 1'b1;
    cli.wr_data = 8'h88;
    step();
    cli.wr_req = 1'b0;
    cli.rd_req = 1'b1;
    step();
    cli.rd_req = 1'b0;
    check("clr_rd_in_read", int'(ram_chip_sel & ~ram_rw_sel), 1);
    r0 = rd_valids;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (3) step();
    check("clr_rd_suppressed", rd_valids - r0, 0);
    check("clr_rd_data_held", int'(cli.rd_data), 8'h77);
    check("clr_rd_count", int'(cli.count), 0);

    // ---------------- asynchronous reset during a WRITE cycle
    cli.wr_req = 1'b1;
    cli.wr_data = 8'h99;
    step();
    cli.wr_req = 1'b0;
    check("mid_wr_cs", int'(ram_chip_sel), 1);
    check("mid_wr_bus_oe", int'(dut.bus_oe), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_bus_oe", int'(dut.bus_oe), 0);
    check("async_cs", int'(ram_chip_sel), 0);
    check("async_count", int'(cli.count), 0);
    check("async_wr_ack", int'(cli.wr_ack), 0);
    check("async_empty", int'(cli.empty), 1);
    #1 rst_n = 1'b1;
    sb.delete();
    repeat (2) step();
    check("post_rst_cs", int'(ram_chip_sel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
